// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the Riscv151 core: serialises icache/dcache requests onto one backing-memory channel.
// Optional one-entry instruction buffer enabled by defining RESPONDER_IBUF_EN.
module riscv_mem_responder #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           icache_addr,
  input  logic                  icache_re,
  output logic [31:0]           icache_dout,
  input  logic [31:0]           dcache_addr,
  input  logic                  dcache_re,
  input  logic [3:0]            dcache_we,
  input  logic [31:0]           dcache_din,
  output logic [31:0]           dcache_dout,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [31:0]           mem_req_data,
  output logic [3:0]            mem_req_mask,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_data
);

  typedef enum logic [2:0] {IDLE, DREQ, DWAIT, IREQ, IWAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] iaddr_q, daddr_q;
  logic [31:0]           din_q;
  logic [3:0]            mask_q;
  logic                  dstore_q;
  logic                  ifetch_q;
  logic [31:0]           icache_dout_q, dcache_dout_q;

  logic                  is_store, is_data, req_any, ibuf_hit, ifetch_new;
  logic [ADDR_WIDTH-1:0] iword, dword;

  assign is_store   = |dcache_we;
  assign is_data    = is_store | dcache_re;
  assign req_any    = is_data | icache_re;
  assign iword      = icache_addr[ADDR_WIDTH+1:2];
  assign dword      = dcache_addr[ADDR_WIDTH+1:2];
  assign ifetch_new = icache_re & ~ibuf_hit;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_addr[31:ADDR_WIDTH+2], icache_addr[1:0],
                              dcache_addr[31:ADDR_WIDTH+2], dcache_addr[1:0]};

`ifdef RESPONDER_IBUF_EN
  logic                  ibuf_valid_q;
  logic [ADDR_WIDTH-1:0] ibuf_tag_q;
  logic [31:0]           ibuf_data_q;

  // A store to the buffered word in the same capture cycle wins over the hit.
  assign ibuf_hit = ibuf_valid_q && (ibuf_tag_q == iword) &&
                    !(is_store && (dword == ibuf_tag_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      ibuf_valid_q <= 1'b0;
      ibuf_tag_q   <= '0;
      ibuf_data_q  <= '0;
    end else if (state_q == IWAIT && mem_resp_valid) begin
      ibuf_valid_q <= 1'b1;
      ibuf_tag_q   <= iaddr_q;
      ibuf_data_q  <= mem_resp_data;
    end else if (state_q == IDLE && is_store && dword == ibuf_tag_q) begin
      ibuf_valid_q <= 1'b0;
    end
  end
`else
  assign ibuf_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = '0;
    case (state_q)
      IDLE: begin
        if (is_data)         state_d = DREQ;
        else if (ifetch_new) state_d = IREQ;
      end
      DREQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = dstore_q;
        mem_req_addr  = daddr_q;
        mem_req_data  = din_q;
        mem_req_mask  = mask_q;
        if (mem_req_ready) begin
          if (!dstore_q)     state_d = DWAIT;
          else if (ifetch_q) state_d = IREQ;
          else               state_d = IDLE;
        end
      end
      DWAIT: begin
        if (mem_resp_valid) state_d = ifetch_q ? IREQ : IDLE;
      end
      IREQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = iaddr_q;
        if (mem_req_ready) state_d = IWAIT;
      end
      IWAIT: begin
        if (mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      iaddr_q       <= '0;
      daddr_q       <= '0;
      din_q         <= '0;
      mask_q        <= '0;
      dstore_q      <= 1'b0;
      ifetch_q      <= 1'b0;
      icache_dout_q <= '0;
      dcache_dout_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_any) begin
        iaddr_q  <= iword;
        daddr_q  <= dword;
        din_q    <= dcache_din;
        mask_q   <= dcache_we;
        dstore_q <= is_store;
        ifetch_q <= ifetch_new;
      end
      if (state_q == DWAIT && mem_resp_valid)
        dcache_dout_q <= mem_resp_data;
      if (state_q == IWAIT && mem_resp_valid)
        icache_dout_q <= mem_resp_data;
`ifdef RESPONDER_IBUF_EN
      else if (state_q == IDLE && icache_re && ibuf_hit)
        icache_dout_q <= ibuf_data_q;
`endif
    end
  end

  assign stall       = (state_q != IDLE);
  assign icache_dout = icache_dout_q;
  assign dcache_dout = dcache_dout_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed self-checking bench for riscv_mem_responder with a simple backing-memory model.
module tb_riscv_mem_responder;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   icache_addr = '0;
  logic          icache_re = 1'b0;
  logic [31:0]   icache_dout;
  logic [31:0]   dcache_addr = '0;
  logic          dcache_re = 1'b0;
  logic [3:0]    dcache_we = '0;
  logic [31:0]   dcache_din = '0;
  logic [31:0]   dcache_dout;
  logic          stall;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [31:0]   mem_req_data;
  logic [3:0]    mem_req_mask;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_data;

  // Memory model: accepts when ready, answers reads one cycle after the handshake.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          model_rv = 1'b0;
  logic [31:0]   model_rd = '0;
  logic          resp_en = 1'b1;
  logic          tb_rv = 1'b0;
  logic [31:0]   tb_rd = '0;
  logic [AW-1:0] hs_addr [$];
  int            hs_count = 0;

  int checks = 0;
  int passed = 0;

  assign mem_resp_valid = model_rv | tb_rv;
  assign mem_resp_data  = tb_rv ? tb_rd : model_rd;

  riscv_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    model_rv <= mem_req_valid && mem_req_ready && !mem_req_rw && resp_en;
    model_rd <= mem[mem_req_addr];
    if (mem_req_valid && mem_req_ready) begin
      hs_addr.push_back(mem_req_addr);
      hs_count = hs_count + 1;
      if (mem_req_rw) begin
        for (int b = 0; b < 4; b++)
          if (mem_req_mask[b]) mem[mem_req_addr][8*b +: 8] = mem_req_data[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({stall, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask} !== '0)
      $display("FAIL reset_req stall=%b valid=%b rw=%b addr=%h data=%h mask=%b expected all 0",
               stall, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask);
    else passed++;
    checks++;
    if (icache_dout !== 32'h0 || dcache_dout !== 32'h0)
      $display("FAIL reset_dout i=%h d=%h expected 0/0", icache_dout, dcache_dout);
    else passed++;
    reset = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_ifetch();
    int n;
    mem[14'h800] = 32'h0000_0013;
    icache_addr = 32'h0000_2000;
    icache_re   = 1'b1;
    tick();
    icache_re = 1'b0;
    checks++;
    if (!(mem_req_valid === 1'b1 && mem_req_addr === 14'h800 && mem_req_rw === 1'b0 && mem_req_mask === 4'h0))
      $display("FAIL ifetch_req valid=%b addr=%h rw=%b mask=%b expected 1/800/0/0",
               mem_req_valid, mem_req_addr, mem_req_rw, mem_req_mask);
    else passed++;
    n = 0;
    while (stall === 1'b1 && n < 50) begin n++; tick(); end
    checks++;
    if (n != 2) $display("FAIL ifetch_stall cycles=%0d expected 2", n);
    else passed++;
    checks++;
    if (icache_dout !== 32'h0000_0013) $display("FAIL ifetch_data got=%h expected 00000013", icache_dout);
    else passed++;
    $display("ifetch 0x2000: stall=%0d dout=%h", n, icache_dout);
  endtask

  task automatic test_load_ifetch();
    int n;
    mem[14'h4] = 32'hCAFE_F00D;
    mem[14'h5] = 32'h0050_0093;
    hs_addr.delete();
    dcache_addr = 32'h10; dcache_re = 1'b1;
    icache_addr = 32'h14; icache_re = 1'b1;
    tick();
    dcache_re = 1'b0; icache_re = 1'b0;
    n = 0;
    while (stall === 1'b1 && n < 50) begin n++; tick(); end
    checks++;
    if (n != 4) $display("FAIL load_ifetch_stall cycles=%0d expected 4", n);
    else passed++;
    checks++;
    if (hs_addr.size() != 2 || hs_addr[0] !== 14'h4 || hs_addr[1] !== 14'h5)
      $display("FAIL load_ifetch_order n=%0d first=%h second=%h expected 2 requests 4 then 5",
               hs_addr.size(), (hs_addr.size() > 0) ? hs_addr[0] : '1,
               (hs_addr.size() > 1) ? hs_addr[1] : '1);
    else passed++;
    checks++;
    if (dcache_dout !== 32'hCAFE_F00D || icache_dout !== 32'h0050_0093)
      $display("FAIL load_ifetch_data d=%h i=%h expected cafef00d/00500093", dcache_dout, icache_dout);
    else passed++;
    $display("load 0x10 + ifetch 0x14: stall=%0d d=%h i=%h", n, dcache_dout, icache_dout);
  endtask

  task automatic test_store_backpressure();
    mem[14'h8] = 32'h1122_3344;
    dcache_addr = 32'h20; dcache_we = 4'b0011; dcache_din = 32'hDEAD_BEEF;
    mem_req_ready = 1'b0;
    tick();
    dcache_we = 4'h0; dcache_din = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_req_ready = 1'b1;
      checks++;
      if (!(stall === 1'b1 && mem_req_valid === 1'b1 && mem_req_rw === 1'b1 && mem_req_addr === 14'h8 &&
            mem_req_mask === 4'b0011 && mem_req_data === 32'hDEAD_BEEF))
        $display("FAIL store_hold c=%0d stall=%b valid=%b rw=%b addr=%h mask=%b data=%h expected 1/1/1/8/0011/deadbeef",
                 c, stall, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_mask, mem_req_data);
      else passed++;
      tick();
    end
    checks++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL store_end stall=%b valid=%b expected 0/0", stall, mem_req_valid);
    else passed++;
    checks++;
    if (mem[14'h8] !== 32'h1122_BEEF || dcache_dout !== 32'hCAFE_F00D)
      $display("FAIL store_effect mem=%h dout=%h expected 1122beef/cafef00d", mem[14'h8], dcache_dout);
    else passed++;
    $display("store 0x20 mask 0011: mem=%h", mem[14'h8]);
  endtask

  task automatic test_store_only();
    dcache_addr = 32'h40; dcache_we = 4'hF; dcache_din = 32'h0BAD_CAFE;
    tick();
    dcache_we = 4'h0;
    checks++;
    if (stall !== 1'b1) $display("FAIL store_only_t1 stall=%b expected 1", stall);
    else passed++;
    tick();
    checks++;
    if (stall !== 1'b0 || mem[14'h10] !== 32'h0BAD_CAFE)
      $display("FAIL store_only_t2 stall=%b mem=%h expected 0/0badcafe", stall, mem[14'h10]);
    else passed++;
    $display("store 0x40: one stall cycle");
  endtask

  task automatic test_reset_abort();
    resp_en = 1'b0;
    icache_addr = 32'h300; icache_re = 1'b1;
    tick();
    icache_re = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (stall !== 1'b0 || icache_dout !== 32'h0)
      $display("FAIL abort_reset stall=%b i=%h expected 0/0", stall, icache_dout);
    else passed++;
    tb_rv = 1'b1; tb_rd = 32'hBAD0_BAD0;
    tick();
    tb_rv = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (stall !== 1'b0 || mem_req_valid !== 1'b0 || icache_dout !== 32'h0)
        $display("FAIL abort_stale c=%0d stall=%b valid=%b i=%h expected 0/0/0",
                 c, stall, mem_req_valid, icache_dout);
      else passed++;
      tick();
    end
    resp_en = 1'b1;
    $display("reset in IWAIT: stale response ignored");
  endtask

  task automatic test_repeat_fetch();
    int hs0;
    mem[14'h40] = 32'h0000_1111;
    icache_addr = 32'h100; icache_re = 1'b1;
    tick();
    icache_re = 1'b0;
    while (stall === 1'b1 && hs_count < 100000) tick();
    hs0 = hs_count;
    icache_re = 1'b1;
    tick();
    icache_re = 1'b0;
`ifdef RESPONDER_IBUF_EN
    checks++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0 || icache_dout !== 32'h0000_1111 || hs_count != hs0)
      $display("FAIL ibuf_hit stall=%b valid=%b i=%h hs=%0d expected 0/0/00001111/%0d",
               stall, mem_req_valid, icache_dout, hs_count, hs0);
    else passed++;
    dcache_addr = 32'h100; dcache_we = 4'hF; dcache_din = 32'h0000_2222;
    tick();
    dcache_we = 4'h0;
    tick();
    icache_re = 1'b1;
    tick();
    icache_re = 1'b0;
    checks++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_addr !== 14'h40)
      $display("FAIL ibuf_inval stall=%b valid=%b addr=%h expected 1/1/40", stall, mem_req_valid, mem_req_addr);
    else passed++;
    tick(); tick();
    checks++;
    if (stall !== 1'b0 || icache_dout !== 32'h0000_2222)
      $display("FAIL ibuf_refill stall=%b i=%h expected 0/00002222", stall, icache_dout);
    else passed++;
`else
    checks++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_addr !== 14'h40)
      $display("FAIL refetch stall=%b valid=%b addr=%h expected 1/1/40", stall, mem_req_valid, mem_req_addr);
    else passed++;
    tick(); tick();
    checks++;
    if (stall !== 1'b0 || icache_dout !== 32'h0000_1111)
      $display("FAIL refetch_data stall=%b i=%h expected 0/00001111", stall, icache_dout);
    else passed++;
`endif
    $display("repeat fetch 0x100: i=%h", icache_dout);
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (stall !== 1'b0 || mem_req_valid !== 1'b0)
        $display("FAIL idle c=%0d stall=%b valid=%b expected 0/0", c, stall, mem_req_valid);
      else passed++;
      tick();
    end
    $display("idle: 10 cycles quiet");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ifetch();
    test_load_ifetch();
    test_store_backpressure();
    test_store_only();
    test_reset_abort();
    test_repeat_fetch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_mem_responder.md
# riscv_mem_responder

Memory-side responder for the Riscv151 core's instruction and data ports. It accepts the core's per-cycle icache/dcache requests, holds the core with `stall` while it serialises them onto a single-ported backing-memory request/response channel, and returns read data on `icache_dout`/`dcache_dout`. It sits between the core and main memory, standing in for the future caches.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: backing-memory word-address width; `mem_req_addr` = byte address bits `[ADDR_WIDTH+1:2]`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `icache_addr`  in  32  instruction byte address from the core.
- `icache_re`  in  1  instruction read request.
- `icache_dout`  out  32  instruction word returned to the core.
- `dcache_addr`  in  32  data byte address from the core.
- `dcache_re`  in  1  data read request.
- `dcache_we`  in  4  data byte-write mask; any bit set marks a store.
- `dcache_din`  in  32  store data.
- `dcache_dout`  out  32  load data returned to the core.
- `stall`  out  1  core must hold its pipeline while high.
- `mem_req_valid`  out  1  backing-memory request valid.
- `mem_req_ready`  in  1  backing memory accepts the request.
- `mem_req_rw`  out  1  1 = write, 0 = read.
- `mem_req_addr`  out  ADDR_WIDTH  word address.
- `mem_req_data`  out  32  write data.
- `mem_req_mask`  out  4  byte-write mask.
- `mem_resp_valid`  in  1  read data valid, one cycle per read.
- `mem_resp_data`  in  32  read data.

## Operation
- Capture: in IDLE, on any edge where `icache_re`, `dcache_re` or `|dcache_we` is set, latch addresses, `dcache_din`, the mask, and the request flags. A store (`|dcache_we`) takes precedence over `dcache_re`; a store never drives `dcache_dout`.
- FSM states: IDLE, DREQ, DWAIT, IREQ, IWAIT.
  - IDLE -> DREQ if a data access was captured; otherwise -> IREQ if an instruction read was captured (and misses the buffer, see Configuration); otherwise stay.
  - DREQ: `mem_req_valid`=1 with data-side fields. On `mem_req_ready`: store -> IREQ if an ifetch is pending, else IDLE; load -> DWAIT.
  - DWAIT: on `mem_resp_valid`, latch `dcache_dout`; -> IREQ if an ifetch is pending, else IDLE.
  - IREQ: `mem_req_valid`=1, `mem_req_rw`=0, mask 0. On ready -> IWAIT.
  - IWAIT: on `mem_resp_valid`, latch `icache_dout`; -> IDLE.
- `stall` = (state != IDLE). Data is always served before the instruction fetch.
- `mem_req_*` are held stable while `mem_req_valid`=1 and `mem_req_ready`=0; valid is never withdrawn before the handshake.
- `mem_resp_valid` in IDLE, DREQ or IREQ is ignored.
- `icache_dout`/`dcache_dout` are registered and hold their last value until overwritten by a later read.
- Core request inputs are don't-care while `stall`=1; they are sampled only in IDLE.

## Timing
- Reset values: `stall`=0, `icache_dout`=0, `dcache_dout`=0, `mem_req_valid`=0, `mem_req_rw`=0, `mem_req_addr`=0, `mem_req_data`=0, `mem_req_mask`=0, FSM=IDLE.
- Reset mid-transaction aborts it and returns to IDLE. A response to an aborted read that arrives later is ignored.
- Request in cycle T (IDLE). `stall` rises in T+1. Read data is valid in the first cycle where `stall`=0 again.
- With `mem_req_ready`=1 constant and the response in the cycle after the handshake:
  - ifetch only: `stall` high in T+1 and T+2; data valid in T+3.
  - load + ifetch: `stall` high in T+1..T+4.
  - store only: `stall` high in T+1 only.
- Each cycle of `mem_req_ready`=0 or response delay extends `stall` by one cycle.

## Configuration
- `RESPONDER_IBUF_EN` defined: adds a one-entry instruction buffer holding a tag, a word and a valid bit.
  - An ifetch whose word address equals the valid tag is served from the buffer with no memory access and no `stall`; `icache_dout` is updated at the T edge.
  - The buffer is filled on every IWAIT response.
  - The buffer is invalidated on reset and by any store to its word address, at that store's capture.
- Not defined: every ifetch goes through IREQ/IWAIT.

## Test plan
- Ifetch at 0x0000_2000, memory returns 0x0000_0013 one cycle after ready -> `mem_req_addr`=0x800; `stall` high 2 cycles; then `icache_dout`=0x0000_0013.
- Same-cycle load at 0x10 and ifetch at 0x14 -> the data request goes out first (addr 0x4), then the ifetch (addr 0x5); `stall` high 4 cycles; both douts correct.
- Store, `dcache_we`=4'b0011, `dcache_din`=0xDEADBEEF to 0x20, with `mem_req_ready` low for 3 cycles -> `mem_req_valid`, addr 0x8, mask 0011 and data all held stable; `stall` high 4 cycles; `dcache_dout` unchanged.
- `reset` asserted in IWAIT, then a stale `mem_resp_valid` arrives -> IDLE, `stall`=0, `icache_dout`=0 and stays 0.
- `RESPONDER_IBUF_EN`: two fetches of 0x100 -> the second has no `mem_req_valid` and no `stall`. A store to 0x100 followed by a fetch of 0x100 -> the fetch goes to memory.
- No request flags set for 10 cycles -> `stall`=0 and `mem_req_valid`=0 throughout.
